// File: rtl/alu_seq_param.sv
`default_nettype none
//==============================================================================
// Module  : alu_seq_param
// Desc    : Registered 16-op ALU with valid/ready handshakes. Define ALU_DIV_EN
//           to build the iterative restoring divider for opcode 0011.
// Rev     : 1.0  initial release
//==============================================================================
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [3:0]           i_sel,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [2*WIDTH-1:0]   o_result,
    output logic                 o_carry,
    output logic                 o_zero,
    output logic                 o_err,
    output logic                 o_busy
);

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_MUL  = 4'b0010;
    localparam logic [3:0] c_OP_DIV  = 4'b0011;
    localparam logic [3:0] c_OP_SHL  = 4'b0100;
    localparam logic [3:0] c_OP_SHR  = 4'b0101;
    localparam logic [3:0] c_OP_ROL  = 4'b0110;
    localparam logic [3:0] c_OP_ROR  = 4'b0111;
    localparam logic [3:0] c_OP_AND  = 4'b1000;
    localparam logic [3:0] c_OP_OR   = 4'b1001;
    localparam logic [3:0] c_OP_NAND = 4'b1010;
    localparam logic [3:0] c_OP_NOR  = 4'b1011;
    localparam logic [3:0] c_OP_XOR  = 4'b1100;
    localparam logic [3:0] c_OP_XNOR = 4'b1101;
    localparam logic [3:0] c_OP_GT   = 4'b1110;
    localparam logic [3:0] c_OP_NEG  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ALU_DIV_EN
        S_DIV  = 2'd1,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [2*WIDTH-1:0]     r_result;
    logic                   r_carry;
    logic                   r_zero;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_start_div;
    logic [2*WIDTH-1:0]     w_a_ext;
    logic [2*WIDTH-1:0]     w_b_ext;
    logic [WIDTH-1:0]       w_diff;
    logic [WIDTH-1:0]       w_neg;
    logic [2*WIDTH-1:0]     w_res;
    logic                   w_carry;
    logic                   w_err;

    assign w_accept = i_in_valid && (r_state == S_IDLE);
    assign w_a_ext  = {{WIDTH{1'b0}}, i_a};
    assign w_b_ext  = {{WIDTH{1'b0}}, i_b};
    assign w_diff   = i_a - i_b;
    assign w_neg    = ~i_a + WIDTH'(1);

`ifdef ALU_DIV_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]       r_quo;
    logic [WIDTH-1:0]       r_rem;
    logic [WIDTH-1:0]       r_div;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH:0]         w_rem_sh;
    logic                   w_ge;
    logic [WIDTH-1:0]       w_rem_nx;
    logic [WIDTH-1:0]       w_quo_nx;
    logic                   w_div_last;

    // Restoring step: shift the next dividend bit into the partial remainder
    assign w_rem_sh    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge        = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_nx    = w_ge ? (w_rem_sh[WIDTH-1:0] - r_div) : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx    = {r_quo[WIDTH-2:0], w_ge};
    assign w_div_last  = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_start_div = (i_sel == c_OP_DIV) && (i_b != '0);
`else
    assign w_start_div = 1'b0;
`endif

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (i_sel)
            c_OP_ADD:  begin
                w_res   = w_a_ext + w_b_ext;
                w_carry = w_res[WIDTH];
            end
            c_OP_SUB:  begin
                w_res   = {{WIDTH{1'b0}}, w_diff};
                w_carry = (i_a < i_b);
            end
            c_OP_MUL:  w_res = w_a_ext * w_b_ext;
            c_OP_DIV:  begin
`ifdef ALU_DIV_EN
                // Only the divide-by-zero case resolves here; real divides iterate
                if (i_b == '0) begin
                    w_res = {i_a, {WIDTH{1'b1}}};
                    w_err = 1'b1;
                end
`else
                w_err = 1'b1;
`endif
            end
            c_OP_SHL:  w_res = w_a_ext << 1;
            c_OP_SHR:  w_res = w_a_ext >> 1;
            c_OP_ROL:  w_res = {{WIDTH{1'b0}}, i_a[WIDTH-2:0], i_a[WIDTH-1]};
            c_OP_ROR:  w_res = {{WIDTH{1'b0}}, i_a[0], i_a[WIDTH-1:1]};
            c_OP_AND:  w_res = {{WIDTH{1'b0}}, i_a & i_b};
            c_OP_OR:   w_res = {{WIDTH{1'b0}}, i_a | i_b};
            c_OP_NAND: w_res = {{WIDTH{1'b0}}, ~(i_a & i_b)};
            c_OP_NOR:  w_res = {{WIDTH{1'b0}}, ~(i_a | i_b)};
            c_OP_XOR:  w_res = {{WIDTH{1'b0}}, i_a ^ i_b};
            c_OP_XNOR: w_res = {{WIDTH{1'b0}}, ~(i_a ^ i_b)};
            c_OP_GT:   w_res = {{(2*WIDTH-1){1'b0}}, (i_a > i_b)};
            c_OP_NEG:  w_res = {{WIDTH{1'b0}}, w_neg};
            default:   w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
`ifdef ALU_DIV_EN
                    w_state_nx = w_start_div ? S_DIV : S_DONE;
`else
                    w_state_nx = S_DONE;
`endif
                end
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
                if (w_div_last) begin
                    w_state_nx = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (i_out_ready) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
`ifdef ALU_DIV_EN
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            if (w_accept && !w_start_div) begin
                r_result <= w_res;
                r_carry  <= w_carry;
                r_zero   <= (w_res == '0);
                r_err    <= w_err;
            end
`ifdef ALU_DIV_EN
            if (w_accept && w_start_div) begin
                r_quo <= i_a;
                r_rem <= '0;
                r_div <= i_b;
                r_cnt <= '0;
            end
            if (r_state == S_DIV) begin
                r_quo <= w_quo_nx;
                r_rem <= w_rem_nx;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_div_last) begin
                    r_result <= {w_rem_nx, w_quo_nx};
                    r_carry  <= 1'b0;
                    r_zero   <= ({w_rem_nx, w_quo_nx} == '0);
                    r_err    <= 1'b0;
                end
            end
`endif
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_result    = r_result;
    assign o_carry     = r_carry;
    assign o_zero      = r_zero;
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_param.sv
`default_nettype none
//==============================================================================
// Module  : tb_alu_seq_param
// Desc    : Directed self-checking bench for alu_seq_param (W=8 and W=16).
// Rev     : 1.0  initial release
//==============================================================================
module tb_alu_seq_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [3:0]  sel;
    logic [15:0] result;
    logic        carry, zero, err, busy;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic [3:0]  sel16;
    logic [31:0] result16;
    logic        carry16, zero16, err16, busy16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_param #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_a(a), .i_b(b), .i_sel(sel),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_result(result), .o_carry(carry), .o_zero(zero),
        .o_err(err), .o_busy(busy)
    );

    alu_seq_param #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid16), .o_in_ready(in_ready16),
        .i_a(a16), .i_b(b16), .i_sel(sel16),
        .o_out_valid(out_valid16), .i_out_ready(out_ready16),
        .o_result(result16), .o_carry(carry16), .o_zero(zero16),
        .o_err(err16), .o_busy(busy16)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Issue one op, measure accept-to-out_valid latency, check outputs, then handshake
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] va,
                          input logic [7:0] vb, input logic [15:0] eres, input logic ec,
                          input logic ez, input logic ee, input int elat);
        int lat;
        @(posedge clk); #1;
        in_valid = 1'b1; sel = op; a = va; b = vb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, ".lat"},   64'(lat), 64'(elat));
        check_eq({tag, ".res"},   64'(result), 64'(eres));
        check_eq({tag, ".flags"}, 64'({carry, zero, err}), 64'({ec, ez, ee}));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({tag, ".rel"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        int seen;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b1; a16 = '0; b16 = '0; sel16 = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.outs", 64'({out_valid, busy, carry, zero, err}), 64'(0));
        check_eq("rst.res", 64'(result), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst.ready", 64'({in_ready, busy}), 64'(2'b10));

        run_op("add_ovf", 4'b0000, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 1'b0, 1);
        run_op("add",     4'b0000, 8'h12, 8'h34, 16'h0046, 1'b0, 1'b0, 1'b0, 1);
        run_op("sub_brw", 4'b0001, 8'd3,  8'd5,  16'h00FE, 1'b1, 1'b0, 1'b0, 1);
        run_op("sub",     4'b0001, 8'd5,  8'd3,  16'h0002, 1'b0, 1'b0, 1'b0, 1);
        run_op("mul",     4'b0010, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b0, 1);
        run_op("shl",     4'b0100, 8'h81, 8'h00, 16'h0102, 1'b0, 1'b0, 1'b0, 1);
        run_op("shr",     4'b0101, 8'h81, 8'h00, 16'h0040, 1'b0, 1'b0, 1'b0, 1);
        run_op("rol",     4'b0110, 8'h81, 8'h00, 16'h0003, 1'b0, 1'b0, 1'b0, 1);
        run_op("ror",     4'b0111, 8'h81, 8'h00, 16'h00C0, 1'b0, 1'b0, 1'b0, 1);
        run_op("and",     4'b1000, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1'b0, 1);
        run_op("or",      4'b1001, 8'hF0, 8'h3C, 16'h00FC, 1'b0, 1'b0, 1'b0, 1);
        run_op("nand",    4'b1010, 8'hF0, 8'h3C, 16'h00CF, 1'b0, 1'b0, 1'b0, 1);
        run_op("nor",     4'b1011, 8'hF0, 8'h3C, 16'h0003, 1'b0, 1'b0, 1'b0, 1);
        run_op("xor",     4'b1100, 8'hF0, 8'h3C, 16'h00CC, 1'b0, 1'b0, 1'b0, 1);
        run_op("xnor",    4'b1101, 8'hF0, 8'h3C, 16'h0033, 1'b0, 1'b0, 1'b0, 1);
        run_op("gt_t",    4'b1110, 8'd5,  8'd3,  16'h0001, 1'b0, 1'b0, 1'b0, 1);
        run_op("gt_eq",   4'b1110, 8'd5,  8'd5,  16'h0000, 1'b0, 1'b1, 1'b0, 1);
        run_op("neg0",    4'b1111, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1);
        run_op("neg1",    4'b1111, 8'h01, 8'h00, 16'h00FF, 1'b0, 1'b0, 1'b0, 1);
`ifdef ALU_DIV_EN
        run_op("div",     4'b0011, 8'd200, 8'd7,   16'h041C, 1'b0, 1'b0, 1'b0, 9);
        run_op("div_1",   4'b0011, 8'hFF,  8'd1,   16'h00FF, 1'b0, 1'b0, 1'b0, 9);
        run_op("div_sm",  4'b0011, 8'd7,   8'd200, 16'h0700, 1'b0, 1'b0, 1'b0, 9);
        run_op("div_z",   4'b0011, 8'd0,   8'd5,   16'h0000, 1'b0, 1'b1, 1'b0, 9);
        run_op("div_b0",  4'b0011, 8'd200, 8'd0,   16'hC8FF, 1'b0, 1'b0, 1'b1, 1);
`else
        run_op("div_off", 4'b0011, 8'd200, 8'd7,   16'h0000, 1'b0, 1'b1, 1'b1, 1);
`endif

        // Backpressure: result must hold and new requests must be ignored
        @(posedge clk); #1;
        in_valid = 1'b1; sel = 4'b0000; a = 8'h10; b = 8'h20;
        @(posedge clk); #1;
        sel = 4'b1000; a = 8'h00; b = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp.hold", 64'({out_valid, in_ready, result}), 64'({2'b10, 16'h0030}));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp.rel", 64'({out_valid, in_ready}), 64'(2'b01));
        @(posedge clk); #1;
        check_eq("bp.ignored", 64'({out_valid, result}), 64'({1'b0, 16'h0030}));

        // Reset while an op is in flight
        @(posedge clk); #1;
        in_valid = 1'b1; b = 8'd7; a = 8'd200;
`ifdef ALU_DIV_EN
        sel = 4'b0011;
`else
        sel = 4'b0000;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("mid.busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #2;
        check_eq("mid.rst", 64'({out_valid, busy, result}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_eq("mid.noval", 64'(seen), 64'(0));
        check_eq("mid.ready", 64'({in_ready, result}), 64'({1'b1, 16'h0000}));

        // WIDTH=16 instance
        @(posedge clk); #1;
        in_valid16 = 1'b1; sel16 = 4'b0010; a16 = 16'hFFFF; b16 = 16'hFFFF;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        check_eq("w16.mul", 64'({out_valid16, result16}), 64'({1'b1, 32'hFFFE0001}));
        check_eq("w16.flags", 64'({carry16, zero16, err16}), 64'(0));
`ifndef ALU_DIV_EN
        @(posedge clk); #1;
        in_valid16 = 1'b1; sel16 = 4'b0011; a16 = 16'd1000; b16 = 16'd10;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        check_eq("w16.divoff", 64'({out_valid16, err16, zero16, result16}),
                 64'({3'b111, 32'h0}));
`endif
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
